tof_distance_collector: RTL and testbench
=========================================

// Module: tof_distance_collector
// PURPOSE
// - Downstream of the per-sensor I2C ToF comm modules: gathers distance results from N sensors.
// - Holds the latest result per sensor and serialises results onto one valid/ready stream.
// - Uses round-robin arbitration between sensors.
// - Flags overrun (result lost) and stale (sensor silent) per sensor, for the control logic that consumes ranging data.
// PARAMETERS
// - N_SENSORS    8        number of ToF channels (2..16)
// - DIST_W       16       distance width, mm
// - TIMEOUT_CYC  5000000  cycles without a result before a channel is flagged stale (50 ms at 100 MHz)
// PORTS
// - clk          in   1               system clock, single domain
// - rst_n        in   1               asynchronous, active-low reset
// - meas_valid   in   N_SENSORS       1-cycle strobe per channel: new result on meas_dist
// - meas_dist    in   N_SENSORS*DIST_W  packed distances; channel i at [i*DIST_W +: DIST_W]
// - out_valid    out  1               output slot holds a result
// - out_ready    in   1               consumer accepts when out_valid&&out_ready
// - out_id       out  $clog2(N_SENSORS)  channel index of out_dist
// - out_dist     out  DIST_W          distance of granted channel
// - overrun      out  N_SENSORS       sticky: result overwritten before being forwarded
// - ovr_clr      in   1               1-cycle pulse, clears all overrun bits
// - stale        out  N_SENSORS       channel silent >= TIMEOUT_CYC cycles
// - min_dist     out  DIST_W          nearest valid, non-stale distance (optional feature)
// - min_id       out  $clog2(N_SENSORS)  channel of min_dist (optional feature)
// BEHAVIOUR
// - Reset values: out_valid=0, out_id=0, out_dist=0, overrun=0, stale=0, min_dist='1, min_id=0.
// - Internal state cleared on reset: hold regs, pend, rr_ptr, watchdog counters.
// - Capture: meas_valid[i] sampled high at edge E0 -> hold[i]<=meas_dist[i], pend[i]<=1.
// - Overrun: capture while pend[i]=1 and channel i not granted at the same edge.
//   - New value overwrites the held value; overrun[i]<=1.
// - Same-edge capture + grant of channel i:
//   - Grant takes the OLD hold value.
//   - The new value stays pending; pend[i] stays 1.
//   - No overrun.
// - Output slot is free when out_valid=0, or when out_valid&&out_ready at this edge.
//   - Back-to-back transfers: one per cycle while out_ready=1.
// - Arbitration (combinational on pend):
//   - Grant the first pending channel at index >= rr_ptr, wrapping modulo N_SENSORS.
//   - On grant: out_id/out_dist load, out_valid<=1, pend[g]<=0 (unless recaptured), rr_ptr<=g+1 (wraps to 0).
//   - If the slot is free and nothing is pending: out_valid<=0.
// - Latency: meas_valid at E0 -> out_valid=1 after E1 if the slot is free and no higher-priority pending channel exists.
// - While out_valid=1 and out_ready=0, out_id and out_dist are held stable.
// - ovr_clr concurrent with a new overrun event: the set wins, bit stays 1.
// - Watchdog, one counter per channel:
//   - Reset to 0 on meas_valid[i]; otherwise increments, saturating at TIMEOUT_CYC.
//   - stale[i]=1 while counter==TIMEOUT_CYC; clears after the edge that captures a new result.
// - Stale does not block forwarding: a late result is still delivered.
// - Reset asserted mid-transfer: out_valid drops immediately (async), and all pending results are discarded.
// CONFIGURATION
// - MIN_TRACK_EN defined:
//   - min_dist/min_id are registered and recomputed every cycle from hold[] over channels that have received >= 1 result and are not stale.
//   - Ties go to the lowest index.
//   - Updated 1 cycle after the capture edge.
//   - No eligible channel -> min_dist='1, min_id=0.
// - MIN_TRACK_EN undefined: no comparator tree; min_dist tied to '1, min_id tied to 0.
// TESTING
// - Ch3 meas_valid, dist=0x01F4, out_ready=1 -> out_valid high 2 edges later, out_id=3, out_dist=0x01F4, for 1 cycle.
// - Ch0,2,5 strobed same cycle, rr_ptr=1 -> grant order 2,5,0; rr_ptr ends at 1.
// - out_ready=0, ch1 strobed 0x0064 then 0x00C8 -> out=0x0064 stays stable, overrun[1]=1.
//   - Release out_ready -> next out=0x00C8.
//   - ovr_clr -> overrun=0.
// - TIMEOUT_CYC=16, ch4 silent 16 cycles -> stale[4]=1.
//   - Strobe ch4 -> stale[4]=0 next cycle; result still forwarded.
// - MIN_TRACK_EN: ch1=300, ch6=120, ch2=120 -> min_dist=120, min_id=2.
//   - Ch2 goes stale -> min_id=6.
// - Assert rst_n low with out_valid=1 and 3 channels pending -> all outputs at reset values; after release, no stale outputs.

Source files
------------

// File: rtl/tof_distance_collector.sv
// rtl/tof_distance_collector.sv - latest-result hold, round-robin serialiser and health flags for N ToF channels (option: MIN_TRACK_EN)
module tof_distance_collector #(
    parameter int N_SENSORS   = 8,
    parameter int DIST_W      = 16,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SENSORS-1:0]          meas_valid,
    input  logic [N_SENSORS*DIST_W-1:0]   meas_dist,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N_SENSORS)-1:0]  out_id,
    output logic [DIST_W-1:0]             out_dist,
    output logic [N_SENSORS-1:0]          overrun,
    input  logic                          ovr_clr,
    output logic [N_SENSORS-1:0]          stale,
    output logic [DIST_W-1:0]             min_dist,
    output logic [$clog2(N_SENSORS)-1:0]  min_id
);

    localparam int ID_W  = $clog2(N_SENSORS);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(N_SENSORS - 1);

    logic [DIST_W-1:0]    holdReg [N_SENSORS];
    logic [N_SENSORS-1:0] pend;
    logic [ID_W-1:0]      rrPtr;
    logic [CNT_W-1:0]     wdCnt [N_SENSORS];

    logic            slotFree;
    logic            grantValid;
    logic            doGrant;
    logic [ID_W-1:0] grantId;
    int              scanIdx;

    // Round-robin pick: first pending channel at or after rrPtr, wrapping around
    always_comb begin
        grantValid = 1'b0;
        grantId    = '0;
        scanIdx    = 0;
        for (int k = 0; k < N_SENSORS; k++) begin
            scanIdx = int'(rrPtr) + k;
            if (scanIdx >= N_SENSORS) begin
                scanIdx = scanIdx - N_SENSORS;
            end
            if (!grantValid && pend[scanIdx]) begin
                grantValid = 1'b1;
                grantId    = ID_W'(scanIdx);
            end
        end
    end

    assign slotFree = !out_valid || out_ready;
    assign doGrant  = slotFree && grantValid;

    // Output slot: load the granted channel when the slot frees up, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_dist  <= '0;
            rrPtr     <= '0;
        end else if (slotFree) begin
            if (grantValid) begin
                out_valid <= 1'b1;
                out_id    <= grantId;
                out_dist  <= holdReg[grantId];
                rrPtr     <= (grantId == LAST_ID) ? '0 : grantId + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Per-channel capture, pending tracking, sticky overrun and silence watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            overrun <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                holdReg[i] <= '0;
                wdCnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                // A capture on the grant edge is not a loss: the old value leaves via the slot
                if (meas_valid[i] && pend[i] && !(doGrant && grantId == ID_W'(i))) begin
                    overrun[i] <= 1'b1;
                end else if (ovr_clr) begin
                    overrun[i] <= 1'b0;
                end
                if (meas_valid[i]) begin
                    holdReg[i] <= meas_dist[i*DIST_W +: DIST_W];
                    pend[i]    <= 1'b1;
                    wdCnt[i]   <= '0;
                end else begin
                    if (doGrant && grantId == ID_W'(i)) begin
                        pend[i] <= 1'b0;
                    end
                    if (wdCnt[i] != TIMEOUT_VAL) begin
                        wdCnt[i] <= wdCnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // A channel is stale once its watchdog has saturated
    always_comb begin
        stale = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            stale[i] = (wdCnt[i] == TIMEOUT_VAL);
        end
    end

`ifdef MIN_TRACK_EN
    logic [N_SENSORS-1:0] seen;
    logic [DIST_W-1:0]    minDNext;
    logic [ID_W-1:0]      minINext;
    logic                 minFound;

    // Remember which channels have delivered at least one result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
        end else begin
            seen <= seen | meas_valid;
        end
    end

    // Nearest eligible channel; strict compare keeps the lowest index on ties
    always_comb begin
        minDNext = '1;
        minINext = '0;
        minFound = 1'b0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (seen[i] && !stale[i] && (!minFound || holdReg[i] < minDNext)) begin
                minFound = 1'b1;
                minDNext = holdReg[i];
                minINext = ID_W'(i);
            end
        end
    end

    // Register the nearest-distance result every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_dist <= '1;
            min_id   <= '0;
        end else begin
            min_dist <= minDNext;
            min_id   <= minINext;
        end
    end
`else
    assign min_dist = '1;
    assign min_id   = '0;
`endif

endmodule

// File: tb/tb_tof_distance_collector.sv
// tb/tb_tof_distance_collector.sv - self-checking bench for tof_distance_collector
module tb_tof_distance_collector;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int TO = 16;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   meas_valid = '0;
    logic [N*W-1:0] meas_dist = '0;
    logic           out_ready = 1'b0;
    logic           ovr_clr = 1'b0;
    logic           out_valid;
    logic [IW-1:0]  out_id;
    logic [W-1:0]   out_dist;
    logic [N-1:0]   overrun;
    logic [N-1:0]   stale;
    logic [W-1:0]   min_dist;
    logic [IW-1:0]  min_id;

    always #5 clk = ~clk;

    tof_distance_collector #(.N_SENSORS(N), .DIST_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .meas_valid(meas_valid), .meas_dist(meas_dist),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_dist(out_dist),
        .overrun(overrun), .ovr_clr(ovr_clr), .stale(stale),
        .min_dist(min_dist), .min_id(min_id)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] one(input int ch, input logic [W-1:0] d);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = d;
        return r;
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        meas_valid = '0;
        meas_dist = '0;
        out_ready = 1'b0;
        ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, then sample just after the active edge
    task automatic cycle(input logic [N-1:0] mv, input logic [N*W-1:0] md, input logic rdy, input logic clr);
        meas_valid = mv;
        meas_dist = md;
        out_ready = rdy;
        ovr_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chkResetOutputs(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_out"}, {out_id, out_dist}, 0);
        chk({nm, "_ovr"}, overrun, 0);
        chk({nm, "_stale"}, stale, 0);
        chk({nm, "_min"}, {min_id, min_dist}, {3'd0, 16'hFFFF});
    endtask

    // Reference model: channel mailboxes plus a circular scan for the next grant
    logic [W-1:0] mHold [N];
    bit           mPend [N];
    bit           mSeen [N];
    bit           mOvr  [N];
    int           mAge  [N];
    int           mRr;
    bit           mOv;
    logic [IW-1:0] mOid;
    logic [W-1:0] mOdist;
    logic [W-1:0] mMinD;
    logic [IW-1:0] mMinI;

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mHold[i] = '0; mPend[i] = 0; mSeen[i] = 0; mOvr[i] = 0; mAge[i] = 0;
        end
        mRr = 0; mOv = 0; mOid = '0; mOdist = '0; mMinD = '1; mMinI = '0;
    endtask

    task automatic modelStep(input logic [N-1:0] mv, input logic [N*W-1:0] md, input bit rdy, input bit clr);
        int g;
        bit found;
        logic [W-1:0] bestD;
        int bestI;
        found = 0; bestD = '1; bestI = 0;
        for (int i = 0; i < N; i++) begin
            if (mSeen[i] && mAge[i] < TO && (!found || mHold[i] < bestD)) begin
                found = 1; bestD = mHold[i]; bestI = i;
            end
        end
        g = -1;
        if (!mOv || rdy) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mPend[(mRr + k) % N]) g = (mRr + k) % N;
            end
            if (g >= 0) begin
                mOv = 1; mOid = IW'(g); mOdist = mHold[g]; mRr = (g + 1) % N;
            end else begin
                mOv = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (mv[i]) begin
                if (mPend[i] && g != i) mOvr[i] = 1;
                else if (clr) mOvr[i] = 0;
                mHold[i] = md[i*W +: W];
                mPend[i] = 1; mSeen[i] = 1; mAge[i] = 0;
            end else begin
                if (clr) mOvr[i] = 0;
                if (g == i) mPend[i] = 0;
                if (mAge[i] < TO) mAge[i]++;
            end
        end
        mMinD = bestD; mMinI = IW'(bestI);
    endtask

    typedef struct {
        int           ch;
        logic [W-1:0] d;
        bit           stb;
        bit           rdy;
        bit           clr;
        bit           expV;
        int           expId;
        logic [W-1:0] expD;
        logic [N-1:0] expOvr;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [N-1:0]   mv;
        logic [N*W-1:0] md;
        bit rdy, clr;
        int anyValid;
        logic [N-1:0] expStale;

        vt[0]  = '{3, 16'h01F4, 1, 1, 0, 0, 0, 16'h0000, 8'h00};
        vt[1]  = '{3, 16'h0000, 0, 1, 0, 1, 3, 16'h01F4, 8'h00};
        vt[2]  = '{3, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 8'h00};
        vt[3]  = '{1, 16'h0064, 1, 0, 0, 0, 0, 16'h0000, 8'h00};
        vt[4]  = '{1, 16'h00C8, 1, 0, 0, 1, 1, 16'h0064, 8'h00};
        vt[5]  = '{1, 16'h00C8, 1, 0, 0, 1, 1, 16'h0064, 8'h02};
        vt[6]  = '{1, 16'h0000, 0, 1, 0, 1, 1, 16'h00C8, 8'h02};
        vt[7]  = '{1, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 8'h00};
        vt[8]  = '{2, 16'h0010, 1, 0, 0, 0, 0, 16'h0000, 8'h00};
        vt[9]  = '{2, 16'h0020, 1, 0, 0, 1, 2, 16'h0010, 8'h00};
        vt[10] = '{2, 16'h0030, 1, 0, 1, 1, 2, 16'h0010, 8'h04};
        vt[11] = '{2, 16'h0000, 0, 1, 0, 1, 2, 16'h0030, 8'h04};
        vt[12] = '{2, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 8'h00};

        // Reset state, then directed latency / overrun / clear vectors
        doReset();
        chkResetOutputs("reset");
        for (int r = 0; r < 13; r++) begin
            cycle(vt[r].stb ? N'(1) << vt[r].ch : '0, one(vt[r].ch, vt[r].d), vt[r].rdy, vt[r].clr);
            chk($sformatf("vec%0d_valid", r), out_valid, vt[r].expV);
            if (vt[r].expV) chk($sformatf("vec%0d_out", r), {out_id, out_dist}, {IW'(vt[r].expId), vt[r].expD});
            chk($sformatf("vec%0d_ovr", r), overrun, vt[r].expOvr);
        end

        // Round-robin order from rrPtr=1
        doReset();
        cycle(8'h01, one(0, 16'h0007), 1, 0);
        cycle('0, '0, 1, 0);
        chk("rr_seed", {out_valid, out_id}, {1'b1, 3'd0});
        cycle('0, '0, 1, 0);
        cycle(8'h25, one(0, 16'h00A0) | one(2, 16'h00A2) | one(5, 16'h00A5), 1, 0);
        chk("rr_idle", out_valid, 0);
        cycle('0, '0, 1, 0);
        chk("rr_g0", {out_valid, out_id, out_dist}, {1'b1, 3'd2, 16'h00A2});
        cycle('0, '0, 1, 0);
        chk("rr_g1", {out_valid, out_id, out_dist}, {1'b1, 3'd5, 16'h00A5});
        cycle('0, '0, 1, 0);
        chk("rr_g2", {out_valid, out_id, out_dist}, {1'b1, 3'd0, 16'h00A0});
        cycle(8'h03, one(0, 16'h00B0) | one(1, 16'h00B1), 1, 0);
        cycle('0, '0, 1, 0);
        chk("rr_ptr_end", {out_valid, out_id, out_dist}, {1'b1, 3'd1, 16'h00B1});
        cycle('0, '0, 1, 0);
        chk("rr_wrap", {out_valid, out_id, out_dist}, {1'b1, 3'd0, 16'h00B0});

        // Watchdog boundary and late delivery
        doReset();
        repeat (TO - 1) cycle('0, '0, 1, 0);
        chk("stale_before", stale, 8'h00);
        cycle('0, '0, 1, 0);
        chk("stale_at", stale, 8'hFF);
        cycle(8'h10, one(4, 16'h0123), 1, 0);
        chk("stale_clear", stale, 8'hEF);
        cycle('0, '0, 1, 0);
        chk("stale_fwd", {out_valid, out_id, out_dist}, {1'b1, 3'd4, 16'h0123});

        // Asynchronous reset mid-transfer with three channels pending
        doReset();
        cycle(8'h01, one(0, 16'h0011), 0, 0);
        cycle(8'h0E, one(1, 16'h0021) | one(2, 16'h0022) | one(3, 16'h0023), 0, 0);
        chk("rst_pre", {out_valid, out_id}, {1'b1, 3'd0});
        #2;
        rst_n = 1'b0;
        #1;
        chkResetOutputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        anyValid = 0;
        repeat (5) begin
            cycle('0, '0, 1, 0);
            if (out_valid) anyValid++;
        end
        chk("rst_no_stale_out", anyValid, 0);

        // Nearest-distance tracking
        doReset();
        cycle(8'h46, one(1, 16'd300) | one(6, 16'd120) | one(2, 16'd120), 1, 0);
        cycle('0, '0, 1, 0);
`ifdef MIN_TRACK_EN
        chk("min_tie", {min_id, min_dist}, {3'd2, 16'd120});
        repeat (20) cycle(8'h42, one(1, 16'd300) | one(6, 16'd120), 1, 0);
        chk("min_stale", {min_id, min_dist}, {3'd6, 16'd120});
`else
        chk("min_off", {min_id, min_dist}, {3'd0, 16'hFFFF});
`endif

        // Randomised traffic against the reference model
        doReset();
        modelReset();
        for (int it = 0; it < 1500; it++) begin
            int rate;
            rate = ((it / 300) % 3 == 0) ? 4 : (((it / 300) % 3 == 1) ? 16 : 2);
            mv = '0;
            for (int i = 0; i < N; i++) begin
                mv[i] = ($urandom % rate) == 0;
                md[i*W +: W] = W'($urandom);
            end
            rdy = ($urandom % 4) != 0;
            clr = ($urandom % 16) == 0;
            modelStep(mv, md, rdy, clr);
            cycle(mv, md, rdy, clr);
            chk("rand_valid", out_valid, mOv);
            if (mOv) chk("rand_out", {out_id, out_dist}, {mOid, mOdist});
            chk("rand_ovr", overrun, {mOvr[7], mOvr[6], mOvr[5], mOvr[4], mOvr[3], mOvr[2], mOvr[1], mOvr[0]});
            for (int i = 0; i < N; i++) expStale[i] = (mAge[i] >= TO);
            chk("rand_stale", stale, expStale);
`ifdef MIN_TRACK_EN
            chk("rand_min", {min_id, min_dist}, {mMinI, mMinD});
`else
            chk("rand_min", {min_id, min_dist}, {3'd0, 16'hFFFF});
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
